// File: rtl/pll_vdp_lock_seq.sv
// VDP PLL lock sequencer: PLL reset, lock qualification, downstream reset.
// Optional lock timeout retry: define PLL_VDP_LOCK_TIMEOUT_EN.
module pll_vdp_lock_seq #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] loss_cnt,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam longint CAP = longint'(1) << CNT_W;

  // Elaboration-time sanity check of the counter sizing.
  if (RST_CYCLES < 1 || STABLE_CYCLES < 1 ||
      longint'(RST_CYCLES) >= CAP ||
      longint'(STABLE_CYCLES) >= CAP ||
      longint'(LOCK_TIMEOUT) >= CAP) begin : g_bad_cfg
    $error("pll_vdp_lock_seq: bad parameters");
  end

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_VDP_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       loss_n;
  logic             s1, lk;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      lk <= 1'b0;
    end else begin
      s1 <= pll_locked;
      lk <= s1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    loss_n  = loss_cnt;
    if (soft_req) begin
      state_n = PLL_RST;
      cnt_n   = '0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_n = STABLE;
            cnt_n   = '0;
          end
`ifdef PLL_VDP_LOCK_TIMEOUT_EN
          else if (cnt == TMO_LAST) begin
            state_n = PLL_RST;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
`else
          // Wait forever; saturate instead of wrapping.
          else if (cnt != '1) begin
            cnt_n = cnt + 1'b1;
          end
`endif
        end
        STABLE: begin
          if (!lk) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STB_LAST) begin
            state_n = RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state_n = PLL_RST;
            cnt_n   = '0;
            if (loss_cnt != 8'hff) begin
              loss_n = loss_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_n = PLL_RST;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state    <= PLL_RST;
      cnt      <= '0;
      loss_cnt <= 8'd0;
      pll_rst  <= 1'b1;
      sys_rst  <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      loss_cnt <= loss_n;
      pll_rst  <= (state_n == PLL_RST);
      sys_rst  <= (state_n != RUN);
      ready    <= (state_n == RUN);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_vdp_lock_seq.sv
// Randomised self-checking bench for pll_vdp_lock_seq.
// Reference model tracks phase and time-in-phase from the lock pin history.
module tb_pll_vdp_lock_seq;

  localparam int RST_C = 4;
  localparam int STB_C = 8;
  localparam int TMO_C = 32;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] loss_cnt;
  logic [1:0] state_o;

  int n_chk = 0;
  int n_fail = 0;

  int m_st;
  int m_t;
  int m_loss;
  bit hist[$];

  pll_vdp_lock_seq #(
    .RST_CYCLES(RST_C),
    .STABLE_CYCLES(STB_C),
    .LOCK_TIMEOUT(TMO_C),
    .CNT_W(8)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .soft_req(soft_req),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .loss_cnt(loss_cnt),
    .state_o(state_o)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_go(input int s);
    m_st = s;
    m_t  = 0;
  endfunction

  function automatic void m_reset();
    m_go(0);
    m_loss = 0;
    hist = '{1'b0, 1'b0};
  endfunction

  // Lock seen by the sequencer is the pin as it was two edges earlier.
  function automatic void m_edge(input bit pin, input bit sreq);
    bit lk;
    lk = hist[1];
    hist.push_front(pin);
    void'(hist.pop_back());
    if (sreq) begin
      m_go(0);
    end else begin
      case (m_st)
        0: begin
          m_t++;
          if (m_t == RST_C) m_go(1);
        end
        1: begin
          if (lk) m_go(2);
`ifdef PLL_VDP_LOCK_TIMEOUT_EN
          else begin
            m_t++;
            if (m_t == TMO_C) m_go(0);
          end
`endif
        end
        2: begin
          if (!lk) m_go(1);
          else begin
            m_t++;
            if (m_t == STB_C) m_go(3);
          end
        end
        default: begin
          if (!lk) begin
            m_go(0);
            if (m_loss < 255) m_loss++;
          end
        end
      endcase
    end
  endfunction

  task automatic check_outs();
    chk("state_o", int'(state_o), m_st);
    chk("pll_rst", int'(pll_rst), int'(m_st == 0));
    chk("sys_rst", int'(sys_rst), int'(m_st != 3));
    chk("ready", int'(ready), int'(m_st == 3));
    chk("loss_cnt", int'(loss_cnt), m_loss);
  endtask

  task automatic cyc(input bit pin, input bit sreq);
    pll_locked = pin;
    soft_req = sreq;
    m_edge(pin, sreq);
    @(negedge refclk);
    check_outs();
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    m_reset();
    #1 check_outs();
    @(negedge refclk);
    rst = 1'b0;
    check_outs();
  endtask

  task automatic lock_latency(input string tag);
    int k;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc(1'b1, 1'b0);
      if (ready) begin
        k = i;
        break;
      end
    end
    chk(tag, k, STB_C + 3);
  endtask

  initial begin
    int hi;
    int pr;
    int ent;
    int first;
    int n;
    int len;
    bit pin;
    bit prev0;
    bit got;

    m_reset();
    repeat (2) @(negedge refclk);
    check_outs();
    rst = 1'b0;

    hi = int'(pll_rst);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0);
      hi += int'(pll_rst);
    end
    chk("rst_hold", hi, RST_C);
    chk("wait_state", int'(state_o), 1);

    lock_latency("rel_lat");
    chk("rel_loss", int'(loss_cnt), 0);

    cyc(1'b0, 1'b1);
    repeat (6) cyc(1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0);
    chk("in_stable", int'(state_o), 2);
    pr = 0;
    repeat (3) begin
      cyc(1'b0, 1'b0);
      pr += int'(pll_rst);
    end
    chk("glitch_state", int'(state_o), 1);
    chk("glitch_prst", pr, 0);
    lock_latency("relock_lat");

    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("loss_e2", int'(sys_rst), 0);
    cyc(1'b0, 1'b0);
    chk("loss_e3_sys", int'(sys_rst), 1);
    chk("loss_e3_pll", int'(pll_rst), 1);
    chk("loss_one", int'(loss_cnt), 1);
    repeat (4) cyc(1'b0, 1'b0);
    lock_latency("lat3");

    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("soft_loss_cnt", int'(loss_cnt), 1);
    chk("soft_state", int'(state_o), 0);
    hi = int'(pll_rst);
    repeat (6) begin
      cyc(1'b0, 1'b0);
      hi += int'(pll_rst);
    end
    chk("soft_hold", hi, RST_C);

    cyc(1'b0, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0);
      if (state_o == 2'd1) begin
        got = 1'b1;
        break;
      end
    end
    chk("to_wait", int'(got), 1);
    ent = 0;
    first = 0;
    prev0 = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      cyc(1'b0, 1'b0);
      if (state_o == 2'd0 && !prev0) begin
        ent++;
        if (first == 0) first = i;
      end
      prev0 = (state_o == 2'd0);
    end
`ifdef PLL_VDP_LOCK_TIMEOUT_EN
    chk("tmo_first", first, TMO_C);
    chk("tmo_count", ent, 2);
`else
    chk("tmo_count", ent, 0);
    chk("tmo_state", int'(state_o), 1);
`endif

    for (int l = 0; l < 300; l++) begin
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        cyc(1'b1, 1'b0);
        if (ready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) chk("run_timeout", 0, 1);
      repeat (4) cyc(1'b0, 1'b0);
    end
    chk("loss_sat", int'(loss_cnt), 255);

    n = 0;
    while (n < 2000) begin
      pin = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 25);
      repeat (len) begin
        cyc(pin, $urandom_range(0, 39) == 0);
        n++;
        if ($urandom_range(0, 299) == 0) rst_pulse();
      end
    end
    rst_pulse();
    chk("rst_loss", int'(loss_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
